uart_fifo_unit: RTL and testbench

- Buffered, parametrised successor to the core's single-byte UART unit. Keeps the same go/done/rors request handshake with the multicycle controller.
- Adds independent RX and TX FIFOs of configurable depth, so the core can queue output bytes and the line can receive bytes before the core asks for them.
- Adds sticky framing/overrun error flags and FIFO status outputs. Sits between the controller/datapath and the txd/rxd pins.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_sync_fifo.sv | 44 ++++
 rtl/uart_fifo_unit.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_fifo_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the buffered UART unit.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic       {REQ_IDLE, REQ_PEND}                  req_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; dout shows the head entry (fall-through).
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_fifo_unit.sv
// Buffered 8N1 UART: go/done/rors request port to the controller, RX/TX FIFOs, sticky errors.
module uart_fifo_unit
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int RX_DEPTH         = 16,
  parameter int TX_DEPTH         = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       go,
  input  logic       rors,
  input  logic [7:0] txdata,
  output logic       done,
  output logic [7:0] rxdata,
  output logic       rx_empty,
  output logic       tx_full,
  input  logic       err_clr,
  output logic       frame_err,
  output logic       overrun,
  output logic       txd,
  input  logic       rxd
);

  localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
  localparam int CW      = $clog2(BIT_CYC) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  // FIFO hookup
  logic       tx_push, tx_pop, tx_empty, tx_full_w;
  logic       rx_push, rx_pop, rx_full, rx_empty_w;
  logic [7:0] tx_dout, rx_dout;
  logic [7:0] txbyte_q, txbyte_d, rx_sh_q, rx_sh_d;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push_i(tx_push), .pop_i(tx_pop), .din_i(txbyte_q),
    .dout_o(tx_dout), .full_o(tx_full_w), .empty_o(tx_empty)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push_i(rx_push), .pop_i(rx_pop), .din_i(rx_sh_q),
    .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty_w)
  );

  assign tx_full  = tx_full_w;
  assign rx_empty = rx_empty_w;

  // Request handshake
  req_state_t req_q, req_d;
  logic       rors_q, rors_d;
  logic [7:0] rxdata_q, rxdata_d;

  always_comb begin
    req_d    = req_q;
    rors_d   = rors_q;
    txbyte_d = txbyte_q;
    rxdata_d = rxdata_q;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    done     = 1'b0;
    case (req_q)
      REQ_IDLE: if (go) begin
        rors_d = rors;
        if (!rors) txbyte_d = txdata;
        req_d = REQ_PEND;
      end
      REQ_PEND: begin
        if (!rors_q && !tx_full_w) begin
          tx_push = 1'b1;
          done    = 1'b1;
          req_d   = REQ_IDLE;
        end else if (rors_q && !rx_empty_w) begin
          rx_pop   = 1'b1;
          rxdata_d = rx_dout;
          done     = 1'b1;
          req_d    = REQ_IDLE;
        end
      end
      default: req_d = REQ_IDLE;
    endcase
  end

  // The popped byte is forwarded in the done cycle, then held by the register.
  assign rxdata = rx_pop ? rx_dout : rxdata_q;

  // TX engine
  tx_state_t     tx_q, tx_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;

  always_comb begin
    tx_d     = tx_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    tx_pop   = 1'b0;
    case (tx_q)
      TX_IDLE: begin
        txd_d = IDLE_LEVEL;
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          tx_sh_d  = tx_dout;
          txd_d    = ~IDLE_LEVEL;
          tx_cnt_d = '0;
          tx_d     = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          txd_d    = tx_sh_q[0];
          tx_sh_d  = tx_sh_q >> 1;
          tx_bit_d = '0;
          tx_d     = TX_DATA;
        end else tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == IDX_LAST) begin
            txd_d = IDLE_LEVEL;
            tx_d  = TX_STOP;
          end else begin
            txd_d    = tx_sh_q[0];
            tx_sh_d  = tx_sh_q >> 1;
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit so queued frames are gap-free.
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            tx_sh_d = tx_dout;
            txd_d   = ~IDLE_LEVEL;
            tx_d    = TX_START;
          end else tx_d = TX_IDLE;
        end else tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  assign txd = txd_q;

  // RX engine
  rx_state_t     rx_q, rx_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic          fe_set, ov_set, frame_err_q, overrun_q;

  always_comb begin
    rx_d     = rx_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_push  = 1'b0;
    fe_set   = 1'b0;
    ov_set   = 1'b0;
    case (rx_q)
      RX_IDLE: if (rx_s3_q && !rx_s2_q) begin
        rx_cnt_d = '0;
        rx_d     = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_d     = rx_s2_q ? RX_IDLE : RX_DATA;
        end else rx_cnt_d = rx_cnt_q + CNT_ONE;
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == IDX_LAST) rx_d = RX_STOP;
          else                      rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + CNT_ONE;
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_d     = RX_IDLE;
          if (!rx_s2_q)     fe_set  = 1'b1;
          else if (rx_full) ov_set  = 1'b1;
          else              rx_push = 1'b1;
        end else rx_cnt_d = rx_cnt_q + CNT_ONE;
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q       <= REQ_IDLE;
      rors_q      <= 1'b0;
      txbyte_q    <= '0;
      rxdata_q    <= '0;
      tx_q        <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      txd_q       <= IDLE_LEVEL;
      rx_q        <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_s1_q     <= IDLE_LEVEL;
      rx_s2_q     <= IDLE_LEVEL;
      rx_s3_q     <= IDLE_LEVEL;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      req_q       <= req_d;
      rors_q      <= rors_d;
      txbyte_q    <= txbyte_d;
      rxdata_q    <= rxdata_d;
      tx_q        <= tx_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      txd_q       <= txd_d;
      rx_q        <= rx_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_s1_q     <= rxd;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      // A new error event outranks a simultaneous clear.
      frame_err_q <= fe_set | (frame_err_q & ~err_clr);
      overrun_q   <= ov_set | (overrun_q & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_fifo_unit.sv
// Directed/randomized bench for uart_fifo_unit with a queue-based reference model.
module tb_uart_fifo_unit;

  localparam int H    = 4;
  localparam int BITC = 2 * H;

  logic       clk = 1'b0, rstn = 1'b0, go = 1'b0, rors = 1'b0, err_clr = 1'b0, rxd = 1'b1;
  logic [7:0] txdata = 8'h00;
  logic       done, rx_empty, tx_full, frame_err, overrun, txd;
  logic [7:0] rxdata;

  uart_fifo_unit #(.CLK_PER_HALF_BIT(H), .RX_DEPTH(4), .TX_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .go(go), .rors(rors), .txdata(txdata), .done(done),
    .rxdata(rxdata), .rx_empty(rx_empty), .tx_full(tx_full), .err_clr(err_clr),
    .frame_err(frame_err), .overrun(overrun), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;

  // Line monitor: frames decoded from txd, their start cycles, and bit-stability flags.
  bit         mon_en = 1'b0;
  logic [7:0] mon_q[$];
  int         mon_st[$];
  bit         mon_ok[$];

  initial forever begin
    @(negedge clk);
    if (mon_en && rstn && txd === 1'b0) begin
      logic [9:0] bits;
      logic       cur;
      bit         ok;
      int         st;
      st = cyc; ok = 1'b1; cur = 1'b0; bits = '0;
      for (int k = 0; k < 10 * BITC; k++) begin
        if (k > 0) @(negedge clk);
        if (k % BITC == 0) begin
          cur = txd;
          bits[k / BITC] = cur;
        end else if (txd !== cur) ok = 1'b0;
      end
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
      mon_q.push_back(bits[8:1]);
      mon_st.push_back(st);
      mon_ok.push_back(ok);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, output int lat);
    @(negedge clk); go = 1'b1; rors = 1'b0; txdata = b;
    @(negedge clk); go = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 3000) begin @(negedge clk); lat++; end
  endtask

  task automatic recv(output logic [7:0] rd, output int lat);
    @(negedge clk); go = 1'b1; rors = 1'b1;
    @(negedge clk); go = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 3000) begin @(negedge clk); lat++; end
    rd = rxdata;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (BITC) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (mon_q.size() < n && t < 2000) begin @(negedge clk); t++; end
    chk("frame_count", mon_q.size(), n);
  endtask

  logic [7:0] rx_model[$];
  logic [7:0] tx_exp[$];
  logic [7:0] b, rd;
  int         lat;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1); chk("rst_done", done, 0); chk("rst_rxdata", rxdata, 0);
    chk("rst_rx_empty", rx_empty, 1); chk("rst_tx_full", tx_full, 0);
    chk("rst_frame_err", frame_err, 0); chk("rst_overrun", overrun, 0);
    rstn = 1'b1;

    // Reset in the middle of a frame drops txd high at once
    send(8'h11, lat);
    repeat (30) @(negedge clk);
    chk("midframe_txd_low", txd, 0);
    rstn = 1'b0;
    #1;
    chk("midrst_txd", txd, 1); chk("midrst_rx_empty", rx_empty, 1);
    chk("midrst_tx_full", tx_full, 0); chk("midrst_done", done, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Single send
    send(8'hA5, lat);
    chk("send_a5_lat", lat, 1);
    wait_frames(1);
    chk("send_a5_byte", mon_q[0], 8'hA5);
    chk("send_a5_shape", mon_ok[0], 1);
    mon_q.delete(); mon_st.delete(); mon_ok.delete();
    repeat (5) @(negedge clk);

    // Back-to-back sends: one goes on the line, four fill the FIFO, the sixth stalls
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      tx_exp.push_back(b);
      if (i == 5) begin
        @(negedge clk);
        chk("burst_tx_full", tx_full, 1);
      end
      send(b, lat);
      if (i < 5) chk("burst_lat", lat, 1);
      else       chk("burst_stall", (lat > 40 && lat < 200) ? 1 : 0, 1);
    end
    wait_frames(6);
    for (int i = 0; i < 6; i++) begin
      chk("burst_byte", mon_q[i], tx_exp[i]);
      chk("burst_shape", mon_ok[i], 1);
      if (i > 0) chk("burst_gapfree", mon_st[i] - mon_st[i-1], 10 * BITC);
    end
    chk("burst_tx_full_end", tx_full, 0);

    // Single receive of 0x3C, then a few random receives
    rx_frame(8'h3C, 1'b1);
    rx_model.push_back(8'h3C);
    chk("rx_nonempty", rx_empty, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        b = 8'($urandom);
        rx_frame(b, 1'b1);
        rx_model.push_back(b);
      end
      recv(rd, lat);
      chk("rx_lat", lat, 1);
      chk("rx_data", rd, rx_model.pop_front());
      @(negedge clk);
      chk("rx_empty_after", rx_empty, 1);
      repeat (4) @(negedge clk);
      chk("rx_hold", rxdata, rd);
    end

    // Overrun: five frames into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      rx_frame(b, 1'b1);
      if (rx_model.size() < 4) rx_model.push_back(b);
    end
    chk("ovr_flag", overrun, 1); chk("ovr_no_fe", frame_err, 0);
    while (rx_model.size() > 0) begin
      recv(rd, lat);
      chk("ovr_data", rd, rx_model.pop_front());
    end
    @(negedge clk);
    chk("ovr_empty", rx_empty, 1);
    chk("ovr_sticky", overrun, 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Framing error, then a short glitch
    rx_frame(8'h55, 1'b0);
    chk("fe_flag", frame_err, 1); chk("fe_empty", rx_empty, 1); chk("fe_no_ovr", overrun, 0);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("fe_clr", frame_err, 0);
    rxd = 1'b0; repeat (2) @(negedge clk); rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_empty", rx_empty, 1); chk("glitch_fe", frame_err, 0); chk("glitch_ovr", overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
